// File: rtl/key_pkg.sv
// Shared types and helpers for the push-button conditioning path.
// Counter sizing and per-channel debounce state live here.
package key_pkg;

    localparam int NUM_KEYS_DEF = 4;

    typedef logic [NUM_KEYS_DEF-1:0] key_vec_t;

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } key_state_e;

    // Width able to hold 0..cycles.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, run-length debounce,
// registered press/release pulses.
module debounce_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    key_state_e    state;
    key_state_e    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          rise_nxt;
    logic          fall_nxt;

    assign level = (state == PRESSED);

    // Synchroniser, debounce state and pulse registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= RELEASED;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    // Count an unbroken run of mismatching samples; flip on the last one.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (sync2 != level) begin
            if (cnt == LAST) begin
                unique case (state)
                    RELEASED: begin
                        state_nxt = PRESSED;
                        rise_nxt  = 1'b1;
                    end
                    PRESSED: begin
                        state_nxt = RELEASED;
                        fall_nxt  = 1'b1;
                    end
                    default: state_nxt = RELEASED;
                endcase
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Board KEY conditioning: polarity fix, per-channel debounce and
// a sticky "pressed since last ack" flag for software.
module key_conditioner
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = NUM_KEYS_DEF,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    input  logic [NUM_KEYS-1:0] ack,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_event
);

    logic [NUM_KEYS-1:0] key_s;

    assign key_s = ACTIVE_LOW ? ~key_raw : key_raw;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .Clk  (Clk),
            .Reset(Reset),
            .din  (key_s[i]),
            .level(key_level[i]),
            .rise (key_press[i]),
            .fall (key_release[i])
        );
    end

    // Sticky event: a press sets it (winning over ack), ack clears it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_event <= '0;
        end else begin
            key_event <= key_press | (key_event & ~ack);
        end
    end

endmodule
